sram_boot_loader: RTL

- Synthesizable boot preloader for byte-lane SRAM macro banks (CEN/GWEN/WEN active-low) serving instruction or data memory.
- Accepts a byte stream (valid/ready), packs LANES bytes little-endian per word and writes words from address 0 upward.
- Optionally reads the region back and checks a 16-bit byte sum.
- Holds the core while it runs, then hands the SRAM ports to the CPU as a transparent mux.

---
 rtl/sram_boot_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sram_boot_loader.sv
// Boot preloader for byte-lane SRAM banks: packs a byte stream into words,
// writes them from address 0, optionally verifies a byte sum, then hands off.
module sram_boot_loader #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int VERIFY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W:0]           load_words,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      busy,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      error,
  input  logic [LANES-1:0]          cpu_cen,
  input  logic [LANES-1:0]          cpu_gwen,
  input  logic [8*LANES-1:0]        cpu_wen,
  input  logic [8*LANES-1:0]        cpu_d,
  input  logic [ADDR_W*LANES-1:0]   cpu_a,
  output logic [8*LANES-1:0]        cpu_q,
  output logic [LANES-1:0]          mem_cen,
  output logic [LANES-1:0]          mem_gwen,
  output logic [8*LANES-1:0]        mem_wen,
  output logic [8*LANES-1:0]        mem_d,
  output logic [ADDR_W*LANES-1:0]   mem_a,
  input  logic [8*LANES-1:0]        mem_q
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_VRD, S_DONE, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [LANES-1:0][7:0]   lane_q, lane_d;
  logic [ADDR_W:0]         addr_q, addr_d;
  logic [ADDR_W:0]         n_q, n_d;
  logic [15:0]             wsum_q, wsum_d;
  logic [15:0]             rsum_q, rsum_d;
  logic [15:0]             qsum;

  logic [LANES-1:0]        ld_cen, ld_gwen;
  logic [8*LANES-1:0]      ld_wen, ld_d;
  logic [ADDR_W*LANES-1:0] ld_a;

  // Byte sum across all lanes of the bank read data.
  always_comb begin
    qsum = '0;
    for (int k = 0; k < LANES; k++) begin
      qsum = qsum + 16'(mem_q[8*k +: 8]);
    end
  end

  // Loader state, byte packing, address and checksum registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      n_q     <= '0;
      wsum_q  <= '0;
      rsum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
    end
  end

  // Next-state and loader-side bank drive.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    addr_d   = addr_q;
    n_d      = n_q;
    wsum_d   = wsum_q;
    rsum_d   = rsum_q;
    in_ready = 1'b0;
    ld_cen   = '1;
    ld_gwen  = '1;
    ld_wen   = '1;
    ld_a     = '0;
    ld_d     = '0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (load_words == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            n_d     = (load_words > DEPTH_W) ? DEPTH_W : load_words;
            addr_d  = '0;
            idx_d   = '0;
            wsum_d  = '0;
            rsum_d  = '0;
          end
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lane_d[idx_q] = in_data;
          wsum_d = wsum_q + 16'(in_data);
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        ld_cen  = '0;
        ld_gwen = '0;
        ld_wen  = '0;
        ld_d    = lane_q;
        for (int k = 0; k < LANES; k++) begin
          ld_a[ADDR_W*k +: ADDR_W] = addr_q[ADDR_W-1:0];
        end
        idx_d = '0;
        if ((addr_q + 1'b1) == n_q) begin
          addr_d  = '0;
          state_d = (VERIFY != 0) ? S_VRD : S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_VRD: begin
        if (addr_q != n_q) begin
          ld_cen = '0;
          for (int k = 0; k < LANES; k++) begin
            ld_a[ADDR_W*k +: ADDR_W] = addr_q[ADDR_W-1:0];
          end
          addr_d = addr_q + 1'b1;
        end
        if (addr_q != '0) begin
          rsum_d = rsum_q + qsum;
        end
        if (addr_q == n_q) begin
          state_d = (rsum_d == wsum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                    (state_q == S_VRD);
  assign cpu_hold = busy;
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);

  assign mem_cen  = busy ? ld_cen  : cpu_cen;
  assign mem_gwen = busy ? ld_gwen : cpu_gwen;
  assign mem_wen  = busy ? ld_wen  : cpu_wen;
  assign mem_d    = busy ? ld_d    : cpu_d;
  assign mem_a    = busy ? ld_a    : cpu_a;
  assign cpu_q    = mem_q;

endmodule
